// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one WISHBONE classic slave between NUM masters,
// with a per-transaction timeout that force-acks cycles the slave never finishes.
module wishbone_rr_arbiter #(
   parameter int NUM          = 2,
   parameter int WB_ADR_BITS  = 38,
   parameter int WB_DAT_BITS  = 32,
   parameter int WB_SEL_BITS  = WB_DAT_BITS / 8,
   parameter int TIMEOUT      = 256,
   parameter logic [WB_DAT_BITS-1:0] TIMEOUT_DATA = 32'hdead_beef
) (
   input  logic                       reset,
   input  logic                       clk,
   input  logic [NUM*WB_ADR_BITS-1:0] s_wb_adr_i,
   input  logic [NUM*WB_DAT_BITS-1:0] s_wb_dat_i,
   input  logic [NUM*WB_SEL_BITS-1:0] s_wb_sel_i,
   input  logic [NUM-1:0]             s_wb_we_i,
   input  logic [NUM-1:0]             s_wb_stb_i,
   output logic [WB_DAT_BITS-1:0]     s_wb_dat_o,
   output logic [NUM-1:0]             s_wb_ack_o,
   output logic [WB_ADR_BITS-1:0]     m_wb_adr_o,
   output logic [WB_DAT_BITS-1:0]     m_wb_dat_o,
   output logic [WB_SEL_BITS-1:0]     m_wb_sel_o,
   output logic                       m_wb_we_o,
   output logic                       m_wb_stb_o,
   input  logic [WB_DAT_BITS-1:0]     m_wb_dat_i,
   input  logic                       m_wb_ack_i,
   output logic                       grant_valid,
   output logic [$clog2(NUM)-1:0]     grant_index,
   output logic [15:0]                timeout_count
);

   localparam int IDX_W = $clog2(NUM);
   localparam int WCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCW-1:0]   WAIT_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [IDX_W:0]   NUM_W     = (IDX_W + 1)'(NUM);
   localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TERM  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     grant_index_q, grant_index_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic                 grant_valid_q, grant_valid_d;
   logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
   logic [15:0]          timeout_count_q, timeout_count_d;

   logic [WB_ADR_BITS-1:0] adr_arr [NUM];
   logic [WB_DAT_BITS-1:0] dat_arr [NUM];
   logic [WB_SEL_BITS-1:0] sel_arr [NUM];

   logic                 g_stb;
   logic [IDX_W-1:0]     rr_winner;
   logic                 rr_found;
   logic [IDX_W:0]       cand;

   generate
      for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
         assign adr_arr[gi] = s_wb_adr_i[gi*WB_ADR_BITS +: WB_ADR_BITS];
         assign dat_arr[gi] = s_wb_dat_i[gi*WB_DAT_BITS +: WB_DAT_BITS];
         assign sel_arr[gi] = s_wb_sel_i[gi*WB_SEL_BITS +: WB_SEL_BITS];
      end
   endgenerate

   // Scan offsets farthest-first so the candidate just after last_q overrides all others.
   always_comb begin
      rr_winner = '0;
      rr_found  = 1'b0;
      cand      = '0;
      for (int k = NUM; k >= 1; k--) begin
         cand = {1'b0, last_q} + (IDX_W + 1)'(k);
         if (cand >= NUM_W) begin
            cand = cand - NUM_W;
         end
         if (s_wb_stb_i[cand[IDX_W-1:0]]) begin
            rr_winner = cand[IDX_W-1:0];
            rr_found  = 1'b1;
         end
      end
   end

   assign g_stb = s_wb_stb_i[grant_index_q];

   always_comb begin
      state_d         = state_q;
      grant_index_d   = grant_index_q;
      last_d          = last_q;
      grant_valid_d   = grant_valid_q;
      wait_cnt_d      = wait_cnt_q;
      timeout_count_d = timeout_count_q;
      case (state_q)
         IDLE: begin
            if (rr_found) begin
               state_d       = GRANT;
               grant_index_d = rr_winner;
               grant_valid_d = 1'b1;
               wait_cnt_d    = '0;
            end
         end
         GRANT: begin
            // Ack beats both an abort and a timeout landing in the same cycle.
            if (m_wb_ack_i || !g_stb) begin
               state_d       = IDLE;
               last_d        = grant_index_q;
               grant_valid_d = 1'b0;
            end else if ((TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST)) begin
               state_d = TERM;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         TERM: begin
            state_d       = IDLE;
            last_d        = grant_index_q;
            grant_valid_d = 1'b0;
            if (timeout_count_q != 16'hffff) begin
               timeout_count_d = timeout_count_q + 16'd1;
            end
         end
         default: begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         grant_index_q   <= '0;
         last_q          <= LAST_RST;
         grant_valid_q   <= 1'b0;
         wait_cnt_q      <= '0;
         timeout_count_q <= '0;
      end else begin
         state_q         <= state_d;
         grant_index_q   <= grant_index_d;
         last_q          <= last_d;
         grant_valid_q   <= grant_valid_d;
         wait_cnt_q      <= wait_cnt_d;
         timeout_count_q <= timeout_count_d;
      end
   end

   assign m_wb_adr_o = adr_arr[grant_index_q];
   assign m_wb_dat_o = dat_arr[grant_index_q];
   assign m_wb_sel_o = sel_arr[grant_index_q];
   assign m_wb_we_o  = s_wb_we_i[grant_index_q];
   assign m_wb_stb_o = (state_q == GRANT) && g_stb;

   always_comb begin
      s_wb_ack_o = '0;
      if (state_q == GRANT) begin
         s_wb_ack_o[grant_index_q] = m_wb_ack_i;
      end else if (state_q == TERM) begin
         s_wb_ack_o[grant_index_q] = 1'b1;
      end
   end

   assign s_wb_dat_o    = (state_q == TERM) ? TIMEOUT_DATA : m_wb_dat_i;
   assign grant_valid   = grant_valid_q;
   assign grant_index   = grant_index_q;
   assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Scoreboard bench for wishbone_rr_arbiter: three masters, TIMEOUT=8, a latency-programmable
// slave that never acks HANG_ADR.
module tb_wishbone_rr_arbiter;
   localparam int NUM = 3;
   localparam int AW  = 38;
   localparam int DW  = 32;
   localparam int SW  = 4;
   localparam int TO  = 8;
   localparam logic [AW-1:0] HANG_ADR = 38'h3ff;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [NUM*AW-1:0]   s_wb_adr_i = '0;
   logic [NUM*DW-1:0]   s_wb_dat_i = '0;
   logic [NUM*SW-1:0]   s_wb_sel_i = '0;
   logic [NUM-1:0]      s_wb_we_i  = '0;
   logic [NUM-1:0]      s_wb_stb_i = '0;
   logic [DW-1:0]       s_wb_dat_o;
   logic [NUM-1:0]      s_wb_ack_o;
   logic [AW-1:0]       m_wb_adr_o;
   logic [DW-1:0]       m_wb_dat_o;
   logic [SW-1:0]       m_wb_sel_o;
   logic                m_wb_we_o;
   logic                m_wb_stb_o;
   logic [DW-1:0]       m_wb_dat_i;
   logic                m_wb_ack_i;
   logic                grant_valid;
   logic [1:0]          grant_index;
   logic [15:0]         timeout_count;

   wishbone_rr_arbiter #(
      .NUM(NUM), .WB_ADR_BITS(AW), .WB_DAT_BITS(DW), .WB_SEL_BITS(SW),
      .TIMEOUT(TO), .TIMEOUT_DATA(32'hdead_beef)
   ) dut (
      .reset(reset), .clk(clk),
      .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_sel_i(s_wb_sel_i),
      .s_wb_we_i(s_wb_we_i), .s_wb_stb_i(s_wb_stb_i),
      .s_wb_dat_o(s_wb_dat_o), .s_wb_ack_o(s_wb_ack_o),
      .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_sel_o(m_wb_sel_o),
      .m_wb_we_o(m_wb_we_o), .m_wb_stb_o(m_wb_stb_o),
      .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i),
      .grant_valid(grant_valid), .grant_index(grant_index), .timeout_count(timeout_count)
   );

   initial forever #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Slave: acks after sl_lat strobe cycles, returns a running access number as read data.
   int sl_lat  = 1;
   int sl_cnt  = 0;
   int acc_cnt = 0;
   int cyc     = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!m_wb_stb_o || m_wb_ack_i) sl_cnt <= 0;
      else                           sl_cnt <= sl_cnt + 1;
      if (m_wb_ack_i) acc_cnt <= acc_cnt + 1;
   end

   assign m_wb_ack_i = m_wb_stb_o && (m_wb_adr_o != HANG_ADR) && (sl_cnt == sl_lat - 1);
   assign m_wb_dat_i = 32'h1234_0000 + acc_cnt;

   typedef struct {
      int          idx;
      logic [31:0] dat;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   exp_n = 0;
   int   ack_t[$];
   logic [NUM-1:0] ack_seen = '0;
   int   req_left[NUM];

   task automatic push_slave(input int idx);
      sb.push_back('{idx, 32'h1234_0000 + exp_n});
      exp_n++;
   endtask

   task automatic push_term(input int idx);
      sb.push_back('{idx, 32'hdead_beef});
   endtask

   // Ack monitor: every master-side ack pops one expectation.
   initial forever begin
      @(negedge clk);
      if (!reset && s_wb_ack_o != '0) begin
         ack_seen = ack_seen | s_wb_ack_o;
         if (sb.size() == 0) begin
            chk("unexpected_ack", {125'd0, s_wb_ack_o}, 128'd0);
         end else begin
            e = sb.pop_front();
            chk("ack_vec", {125'd0, s_wb_ack_o}, 128'(1 << e.idx));
            chk("ack_dat", {96'd0, s_wb_dat_o}, {96'd0, e.dat});
            ack_t.push_back(cyc);
         end
      end
   end

   // Master driver: keep strobing while requests remain, drop in the cycle after the last ack.
   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM; i++) begin
         if (ack_seen[i] && req_left[i] > 0) req_left[i]--;
         s_wb_stb_i[i] = (req_left[i] > 0);
      end
      ack_seen = '0;
   end

   task automatic set_m(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic w);
      s_wb_adr_i[i*AW +: AW] = a;
      s_wb_dat_i[i*DW +: DW] = d;
      s_wb_sel_i[i*SW +: SW] = s;
      s_wb_we_i[i]           = w;
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int i = 0; i < NUM; i++) if (req_left[i] > 0) p = 1'b1;
      return p;
   endfunction

   int  stb_cycles;
   int  hang_cycles;
   bit  wr_check = 1'b0;
   logic [74:0] wr_exp;

   task automatic wait_done(input string tag);
      int n = 0;
      stb_cycles  = 0;
      hang_cycles = 0;
      while ((pending() || grant_valid) && n < 300) begin
         @(negedge clk);
         n++;
         if (m_wb_stb_o) begin
            stb_cycles++;
            if (m_wb_adr_o == HANG_ADR) hang_cycles++;
            if (wr_check) chk("wr_bus", {53'd0, m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o},
                              {53'd0, wr_exp});
         end
      end
      chk({tag, "_budget"}, 128'(n >= 300), 128'd0);
      chk({tag, "_sb_empty"}, 128'(sb.size()), 128'd0);
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      while (!(grant_valid && m_wb_stb_o) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_budget"}, 128'(n >= 100), 128'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_grant_valid"}, 128'(grant_valid), 128'd0);
      chk({tag, "_grant_index"}, 128'(grant_index), 128'd0);
      chk({tag, "_m_stb"}, 128'(m_wb_stb_o), 128'd0);
      chk({tag, "_s_ack"}, 128'(s_wb_ack_o), 128'd0);
      chk({tag, "_tcount"}, 128'(timeout_count), 128'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NUM; i++) req_left[i] = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b0;

      // Simultaneous reads from all masters: grants 0, 1, 2.
      sl_lat = 2;
      for (int i = 0; i < NUM; i++) set_m(i, '0, '0, 4'hf, 1'b0);
      push_slave(0); push_slave(1); push_slave(2);
      for (int i = 0; i < NUM; i++) req_left[i] = 1;
      wait_done("order");
      chk("order_stb_cycles", 128'(stb_cycles), 128'd6);

      // Fairness with a single-cycle slave: alternation, 2 cycles per access.
      sl_lat = 1;
      ack_t.delete();
      for (int k = 0; k < 4; k++) begin push_slave(0); push_slave(1); end
      req_left[0] = 4; req_left[1] = 4;
      wait_done("fair");
      chk("fair_acks", 128'(ack_t.size()), 128'd8);
      for (int k = 1; k < ack_t.size(); k++) chk("fair_gap", 128'(ack_t[k] - ack_t[k-1]), 128'd2);

      // Write passthrough from master 1.
      sl_lat = 3;
      set_m(1, 38'd2, 32'h3333_0000, 4'h8, 1'b1);
      wr_exp   = {38'd2, 32'h3333_0000, 4'h8, 1'b1};
      wr_check = 1'b1;
      push_slave(1);
      req_left[1] = 1;
      wait_done("write");
      wr_check = 1'b0;
      chk("write_stb_cycles", 128'(stb_cycles), 128'd3);
      set_m(1, '0, '0, 4'hf, 1'b0);

      // Timeout: master 0 hits a dead address, master 1 follows.
      sl_lat = 1;
      chk("to_count_before", 128'(timeout_count), 128'd0);
      set_m(0, HANG_ADR, '0, 4'hf, 1'b0);
      set_m(1, 38'd5, '0, 4'hf, 1'b0);
      push_term(0); push_slave(1);
      req_left[0] = 1; req_left[1] = 1;
      wait_done("timeout");
      chk("to_stb_cycles", 128'(hang_cycles), 128'(TO));
      chk("to_count_after", 128'(timeout_count), 128'd1);

      // Ack lands exactly on the last allowed wait cycle: normal completion.
      sl_lat = TO;
      set_m(0, 38'd7, '0, 4'hf, 1'b0);
      push_slave(0);
      req_left[0] = 1;
      wait_done("collide");
      chk("collide_stb_cycles", 128'(stb_cycles), 128'(TO));
      chk("collide_count", 128'(timeout_count), 128'd1);

      // Abort: master 0 drops its strobe mid-wait, master 1 goes next.
      sl_lat = 5;
      set_m(0, 38'd9, '0, 4'hf, 1'b0);
      req_left[0] = 1;
      wait_grant("abort_grant");
      chk("abort_first_idx", 128'(grant_index), 128'd0);
      set_m(1, 38'd10, '0, 4'hf, 1'b0);
      push_slave(1);
      req_left[1] = 1;
      @(negedge clk);
      req_left[0] = 0;
      wait_done("abort");

      // Reset during GRANT of master 2; master 0 must win afterwards.
      sl_lat = 6;
      set_m(0, 38'd11, '0, 4'hf, 1'b0);
      set_m(2, 38'd12, '0, 4'hf, 1'b0);
      req_left[0] = 1; req_left[2] = 1;
      wait_grant("pre_rst_grant");
      chk("pre_rst_idx", 128'(grant_index), 128'd2);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrst");
      push_slave(0); push_slave(2);
      reset = 1'b0;
      wait_done("post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/wishbone_rr_arbiter.md
# wishbone_rr_arbiter

Round-robin arbiter sharing one WISHBONE classic slave port, such as a register block, between NUM requesting masters. Each master sees an independent slave-side port. The granted master's cycle is forwarded unchanged to the shared slave, and its ack and read data are routed back to it. A per-transaction timeout terminates cycles the slave never acks, so one hung access cannot lock out the other masters.

## Interface
Parameters:
- NUM, 2: number of masters, 2..8.
- WB_ADR_BITS, 38: address width.
- WB_DAT_BITS, 32: data width.
- WB_SEL_BITS, WB_DAT_BITS/8: byte-select width.
- TIMEOUT, 256: cycles to wait for slave ack before forced termination; 0 disables the timeout.
- TIMEOUT_DATA, 32'hdead_beef: read data returned to the master on a forced termination.

Ports:
- reset, in, 1: synchronous, active-high.
- clk, in, 1: single clock for the whole block.
- s_wb_adr_i, in, NUM*WB_ADR_BITS: master addresses, packed; master i occupies slice i.
- s_wb_dat_i, in, NUM*WB_DAT_BITS: master write data.
- s_wb_sel_i, in, NUM*WB_SEL_BITS: master byte selects.
- s_wb_we_i, in, NUM: master write enables.
- s_wb_stb_i, in, NUM: master strobes.
- s_wb_dat_o, out, WB_DAT_BITS: read data, broadcast to all masters.
- s_wb_ack_o, out, NUM: per-master ack.
- m_wb_adr_o, out, WB_ADR_BITS: shared slave address.
- m_wb_dat_o, out, WB_DAT_BITS: shared slave write data.
- m_wb_sel_o, out, WB_SEL_BITS: shared slave byte selects.
- m_wb_we_o, out, 1: shared slave write enable.
- m_wb_stb_o, out, 1: shared slave strobe.
- m_wb_dat_i, in, WB_DAT_BITS: slave read data.
- m_wb_ack_i, in, 1: slave ack.
- grant_valid, out, 1: a master currently holds the grant.
- grant_index, out, $clog2(NUM): index of the granted master.
- timeout_count, out, 16: number of forced terminations, saturating at 16'hffff.

## Operation
- The FSM has three states: IDLE, GRANT and TERM.
- **IDLE:** if any s_wb_stb_i bit is high, select a winner by round-robin, latch it into grant_index, and go to GRANT.
- **Priority:** the search starts at (last+1) mod NUM, where last is the previously granted index. After reset, last = NUM-1, so master 0 has highest priority.
- **GRANT:** m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o and m_wb_stb_o are the granted master's inputs, combinationally muxed.
- **GRANT, ack routing:** s_wb_ack_o[g] = m_wb_ack_i and s_wb_dat_o = m_wb_dat_i. All other ack bits stay 0.
- **GRANT, exits:**
  - On m_wb_ack_i: set last = g and go to IDLE.
  - If s_wb_stb_i[g] drops before any ack (abort): set last = g and go to IDLE. No ack is generated.
- **Timeout counter:** wait_cnt counts the cycles spent in GRANT with no ack. It clears on entry to GRANT.
- **Timeout trigger:** if TIMEOUT != 0 and wait_cnt reaches TIMEOUT-1 without an ack, go to TERM.
- **TERM (exactly one cycle):**
  - m_wb_stb_o = 0.
  - s_wb_ack_o[g] = 1 and s_wb_dat_o = TIMEOUT_DATA.
  - timeout_count increments, saturating.
  - Then set last = g and go to IDLE.
- **IDLE outputs:** m_wb_stb_o = 0 and s_wb_ack_o = 0. The other m_wb_* outputs keep muxing the last grant_index; their values are don't-care.
- **Masters' obligation:** a master deasserts stb, or presents a new cycle, in the cycle after its ack. A strobe still high in IDLE is treated as a new request.

## Timing
- **Reset values:** state = IDLE, grant_valid = 0, grant_index = 0, last = NUM-1, s_wb_ack_o = 0, m_wb_stb_o = 0, wait_cnt = 0, timeout_count = 0. Reset mid-transaction abandons the cycle with no ack.
- **Arbitration latency:** a request sampled in IDLE at edge k puts m_wb_stb_o high in the cycle after edge k.
- **Ack path:** combinational from m_wb_ack_i to s_wb_ack_o with zero added latency.
- **Turnaround:** every transaction is followed by one IDLE cycle, so back-to-back throughput is one access per (slave latency + 1) cycles.
- **Timeout timing:** with no ack, m_wb_stb_o is high for exactly TIMEOUT cycles, then TERM gives the forced ack one cycle later.
- **Ack vs timeout collision:** an ack arriving in the same cycle wait_cnt reaches TIMEOUT-1 wins. The cycle completes normally and timeout_count is unchanged.
- **Ack vs abort collision:** an ack and a strobe drop in the same cycle count as a normal completion.
- **Timing to the current grant:** changes to other masters' requests during GRANT have no effect until IDLE.

## Test plan
- **Reset value:** after reset, all three masters read address 0 simultaneously (NUM=3). Grants go in order 0, 1, 2. Each gets exactly one ack with the slave's data, and the other s_wb_ack_o bits are never high.
- **Fairness:** masters 0 and 1 request continuously with a 1-cycle-ack slave. Grants alternate 0, 1, 0, 1, and each access takes 2 cycles.
- **Write passthrough:** master 1 writes adr 2, dat 32'h3333_0000, sel 4'h8. The slave sees exactly those values, with we = 1 for one GRANT cycle plus the wait states.
- **Timeout:** TIMEOUT = 8 and the slave never acks. m_wb_stb_o is high for 8 cycles, then the master gets an ack with 32'hdead_beef, and timeout_count goes 0 to 1. The next master is then granted.
- **Timeout collision:** the ack arrives exactly on cycle 8 with TIMEOUT = 8. The master gets the slave's data, not TIMEOUT_DATA, and timeout_count is unchanged.
- **Abort and reset:** master 0 drops stb mid-wait, giving no ack, and master 1 is granted next. Then reset asserts during GRANT: all outputs return to reset values and master 0 is granted first afterwards.
